acc_display: RTL and testbench

Downstream display stage for the picoMips core. It takes the signed 8-bit accumulator value that the core drives on `LED` and shows it in signed decimal on four 7-segment digits of the DE-series board. Conversion runs as an iterative double-dabble, one shift per cycle, and starts only when the input value changes. Digit outputs are registered and glitch-free.

---
 rtl/display_pkg.sv | 34 +++
 rtl/seg7_decode.sv | 35 +++
 rtl/acc_display.sv | 147 ++++++++++++++
 tb/tb_acc_display.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and segment constants for the accumulator display stage.
package display_pkg;

   localparam int unsigned SEG_W = 7;
   localparam int unsigned BCD_W = 12;
   localparam int unsigned CNT_W = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      LOAD = 2'd2
   } disp_state_t;

   // Segment patterns {g,f,e,d,c,b,a}, lit segment = 0
   localparam logic [SEG_W-1:0] SEG_DIGIT [0:9] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
   };
   localparam logic [SEG_W-1:0] SEG_MINUS = 7'b0111111;
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

   // Double-dabble correction: add 3 to every BCD nibble that is >= 5
   function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] bcd);
      logic [BCD_W-1:0] adj;
      adj = bcd;
      for (int i = 0; i < 3; i++) begin
         if (bcd[i*4 +: 4] >= 4'd5) begin
            adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
         end
      end
      return adj;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD-to-7-segment decoder with blanking and selectable polarity.
module seg7_decode
   import display_pkg::*;
#(
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic [3:0]       i_bcd,
   input  logic             i_blank,
   output logic [SEG_W-1:0] o_seg_c
);

   logic [SEG_W-1:0] w_seg_al;

   // Look up the active-low pattern, then apply board polarity
   always_comb begin
      w_seg_al = SEG_BLANK;
      if (!i_blank) begin
         case (i_bcd)
            4'd0:    w_seg_al = SEG_DIGIT[0];
            4'd1:    w_seg_al = SEG_DIGIT[1];
            4'd2:    w_seg_al = SEG_DIGIT[2];
            4'd3:    w_seg_al = SEG_DIGIT[3];
            4'd4:    w_seg_al = SEG_DIGIT[4];
            4'd5:    w_seg_al = SEG_DIGIT[5];
            4'd6:    w_seg_al = SEG_DIGIT[6];
            4'd7:    w_seg_al = SEG_DIGIT[7];
            4'd8:    w_seg_al = SEG_DIGIT[8];
            4'd9:    w_seg_al = SEG_DIGIT[9];
            default: w_seg_al = SEG_BLANK;
         endcase
      end
      o_seg_c = ACTIVE_LOW ? w_seg_al : ~w_seg_al;
   end

endmodule

// File: rtl/acc_display.sv
// Shows the signed 8-bit picoMips accumulator in decimal on four 7-segment digits.
module acc_display
   import display_pkg::*;
#(
   parameter bit ACTIVE_LOW = 1'b1,
   parameter bit BLANK_LZ   = 1'b1
) (
   input  logic             Clock,
   input  logic             nReset,
   input  logic [7:0]       Value,
   output logic [SEG_W-1:0] HEX0,
   output logic [SEG_W-1:0] HEX1,
   output logic [SEG_W-1:0] HEX2,
   output logic [SEG_W-1:0] HEX3,
   output logic             Busy
);

   localparam logic [SEG_W-1:0] L_BLANK = ACTIVE_LOW ? SEG_BLANK : ~SEG_BLANK;
   localparam logic [SEG_W-1:0] L_MINUS = ACTIVE_LOW ? SEG_MINUS : ~SEG_MINUS;
   localparam logic [SEG_W-1:0] L_ZERO  = ACTIVE_LOW ? SEG_DIGIT[0] : ~SEG_DIGIT[0];
   localparam logic [SEG_W-1:0] L_LZ    = BLANK_LZ ? L_BLANK : L_ZERO;

   disp_state_t      r_state;
   disp_state_t      w_next_state;
   logic [7:0]       r_last;
   logic             r_neg;
   logic [7:0]       r_mag;
   logic [BCD_W-1:0] r_bcd;
   logic [CNT_W-1:0] r_cnt;
   logic             r_busy;
   logic [SEG_W-1:0] r_hex0, r_hex1, r_hex2, r_hex3;

   logic             w_capture;
   logic             w_shift;
   logic             w_load;
   logic             w_busy_next;
   logic [7:0]       w_mag;
   logic             w_blank1;
   logic             w_blank2;
   logic [SEG_W-1:0] w_seg0, w_seg1, w_seg2;

   // State register
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) r_state <= IDLE;
      else         r_state <= w_next_state;
   end

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (Value != r_last) w_next_state = CONV;
         CONV:    if (r_cnt == CNT_W'(7)) w_next_state = LOAD;
         LOAD:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // FSM control outputs
   always_comb begin
      w_capture = 1'b0;
      w_shift   = 1'b0;
      w_load    = 1'b0;
      case (r_state)
         IDLE:    w_capture = (Value != r_last);
         CONV:    w_shift   = 1'b1;
         LOAD:    w_load    = 1'b1;
         default: ;
      endcase
      w_busy_next = (w_next_state != IDLE);
   end

   // Two's-complement negate; -128 yields 0x80, which reads as unsigned 128
   always_comb begin
      w_mag = Value[7] ? 8'(~Value + 8'd1) : Value;
   end

   // Conversion datapath: capture, then one double-dabble step per cycle
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         r_last <= 8'h00;
         r_neg  <= 1'b0;
         r_mag  <= 8'h00;
         r_bcd  <= '0;
         r_cnt  <= '0;
      end else if (w_capture) begin
         r_last <= Value;
         r_neg  <= Value[7];
         r_mag  <= w_mag;
         r_bcd  <= '0;
         r_cnt  <= '0;
      end else if (w_shift) begin
         {r_bcd, r_mag} <= {dd_adjust(r_bcd), r_mag} << 1;
         r_cnt          <= r_cnt + CNT_W'(1);
      end
   end

   // Leading-zero blanking from the finished BCD result
   always_comb begin
      w_blank2 = BLANK_LZ && (r_bcd[11:8] == 4'd0);
      w_blank1 = BLANK_LZ && (r_bcd[11:8] == 4'd0) && (r_bcd[7:4] == 4'd0);
   end

   seg7_decode #(.ACTIVE_LOW(ACTIVE_LOW)) u_dec0 (
      .i_bcd   (r_bcd[3:0]),
      .i_blank (1'b0),
      .o_seg_c (w_seg0)
   );

   seg7_decode #(.ACTIVE_LOW(ACTIVE_LOW)) u_dec1 (
      .i_bcd   (r_bcd[7:4]),
      .i_blank (w_blank1),
      .o_seg_c (w_seg1)
   );

   seg7_decode #(.ACTIVE_LOW(ACTIVE_LOW)) u_dec2 (
      .i_bcd   (r_bcd[11:8]),
      .i_blank (w_blank2),
      .o_seg_c (w_seg2)
   );

   // Display registers: all digits update together on the LOAD edge
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         r_hex0 <= L_ZERO;
         r_hex1 <= L_LZ;
         r_hex2 <= L_LZ;
         r_hex3 <= L_BLANK;
         r_busy <= 1'b0;
      end else begin
         r_busy <= w_busy_next;
         if (w_load) begin
            r_hex0 <= w_seg0;
            r_hex1 <= w_seg1;
            r_hex2 <= w_seg2;
            r_hex3 <= r_neg ? L_MINUS : L_BLANK;
         end
      end
   end

   assign HEX0 = r_hex0;
   assign HEX1 = r_hex1;
   assign HEX2 = r_hex2;
   assign HEX3 = r_hex3;
   assign Busy = r_busy;

endmodule

// File: tb/tb_acc_display.sv
// Scoreboard bench for acc_display: default instance plus an active-high, no-blanking instance.
module tb_acc_display;

   logic       Clock;
   logic       nReset;
   logic [7:0] Value;
   logic [6:0] hex0, hex1, hex2, hex3;
   logic [6:0] zhex0, zhex1, zhex2, zhex3;
   logic       busy, zbusy;

   int total = 0;
   int bad   = 0;

   typedef struct {
      string      name;
      logic [6:0] h3, h2, h1, h0;   // default instance, active-low
      logic [6:0] z3, z2, z1, z0;   // no-blank instance, written active-low
   } exp_t;

   exp_t q[$];
   exp_t cur;
   exp_t rst_exp;
   int   n_starts = 0;
   int   busy_run = 0;
   logic prev_busy = 1'b0;

   acc_display dut (
      .Clock(Clock), .nReset(nReset), .Value(Value),
      .HEX0(hex0), .HEX1(hex1), .HEX2(hex2), .HEX3(hex3), .Busy(busy)
   );

   acc_display #(.ACTIVE_LOW(1'b0), .BLANK_LZ(1'b0)) dut_z (
      .Clock(Clock), .nReset(nReset), .Value(Value),
      .HEX0(zhex0), .HEX1(zhex1), .HEX2(zhex2), .HEX3(zhex3), .Busy(zbusy)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   localparam logic [6:0] BL = 7'b1111111;
   localparam logic [6:0] MN = 7'b0111111;

   function automatic logic [6:0] sg(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return BL;
      endcase
   endfunction

   function automatic exp_t mk(input string n, input logic [6:0] h3, h2, h1, h0,
                               input logic [6:0] z3, z2, z1, z0);
      exp_t e;
      e.name = n;
      e.h3 = h3; e.h2 = h2; e.h1 = h1; e.h0 = h0;
      e.z3 = z3; e.z2 = z2; e.z1 = z1; e.z0 = z0;
      return e;
   endfunction

   // Active-high instance compared against the inverted active-low pattern
   function automatic logic [55:0] pack(input exp_t e);
      return {e.h3, e.h2, e.h1, e.h0, ~e.z3, ~e.z2, ~e.z1, ~e.z0};
   endfunction

   function automatic logic [55:0] disp_now();
      return {hex3, hex2, hex1, hex0, zhex3, zhex2, zhex1, zhex0};
   endfunction

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] expv);
      total++;
      if (got !== expv) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h at %0t", nm, got, expv, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge Clock);
         #1;
      end
   endtask

   // Monitor: pops an expectation whenever Busy falls, checks display is steady otherwise
   always @(negedge Clock) begin
      if (!nReset) begin
         cur       = rst_exp;
         busy_run  = 0;
         prev_busy = 1'b0;
      end else begin
         if (!prev_busy && busy) n_starts++;
         if (prev_busy && !busy) begin
            chk("busy_len", 64'(busy_run), 64'd9);
            busy_run = 0;
            if (q.size() == 0) begin
               chk("unexpected_update", 64'd1, 64'd0);
            end else begin
               cur = q.pop_front();
            end
         end
         if (busy) busy_run++;
         chk({"display_", cur.name}, 64'(disp_now()), 64'(pack(cur)));
         chk("busy_match", 64'(zbusy), 64'(busy));
         prev_busy = busy;
      end
   end

   // Full conversion with explicit latency checks at E0, E8 and E9
   task automatic conv(input logic [7:0] v, input exp_t e);
      Value = v;
      q.push_back(e);
      step(1);
      chk({"busy_e0_", e.name}, 64'(busy), 64'd1);
      step(8);
      chk({"busy_e8_", e.name}, 64'(busy), 64'd1);
      step(1);
      chk({"busy_e9_", e.name}, 64'(busy), 64'd0);
      chk({"hex_e9_", e.name}, 64'(disp_now()), 64'(pack(e)));
      step(2);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e127, em128, em10, e0, e5, e99, e100;
      int   s;

      rst_exp = mk("reset", BL, BL, BL, sg(0),      BL, sg(0), sg(0), sg(0));
      e127    = mk("127",   BL, sg(1), sg(2), sg(7), BL, sg(1), sg(2), sg(7));
      em128   = mk("m128",  MN, sg(1), sg(2), sg(8), MN, sg(1), sg(2), sg(8));
      em10    = mk("m10",   MN, BL, sg(1), sg(0),    MN, sg(0), sg(1), sg(0));
      e0      = mk("zero",  BL, BL, BL, sg(0),      BL, sg(0), sg(0), sg(0));
      e5      = mk("5",     BL, BL, BL, sg(5),      BL, sg(0), sg(0), sg(5));
      e99     = mk("99",    BL, BL, sg(9), sg(9),    BL, sg(0), sg(9), sg(9));
      e100    = mk("100",   BL, sg(1), sg(0), sg(0), BL, sg(1), sg(0), sg(0));
      cur     = rst_exp;

      nReset = 1'b0;
      Value  = 8'h00;
      #12;
      chk("reset_display", 64'(disp_now()), 64'(pack(rst_exp)));
      chk("reset_busy", 64'({busy, zbusy}), 64'd0);
      @(posedge Clock); #1;
      nReset = 1'b1;

      // Value stays equal to the reset value of last: nothing converts
      step(20);
      chk("idle_no_start", 64'(n_starts), 64'd0);

      conv(8'h7F, e127);
      conv(8'h80, em128);
      conv(8'hF6, em10);

      // Rewriting the same value must not start a conversion
      s = n_starts;
      Value = 8'hF6;
      step(15);
      chk("same_value_no_start", 64'(n_starts), 64'(s));

      conv(8'h00, e0);

      // Value changes mid-conversion: first result at E9, second starts at E10
      Value = 8'h05;
      q.push_back(e5);
      step(1);
      chk("busy_e0_5", 64'(busy), 64'd1);
      step(3);
      Value = 8'h63;
      q.push_back(e99);
      step(6);
      chk("busy_e9_5", 64'(busy), 64'd0);
      chk("hex_e9_5", 64'(disp_now()), 64'(pack(e5)));
      step(1);
      chk("busy_e10_99", 64'(busy), 64'd1);
      step(9);
      chk("busy_e19_99", 64'(busy), 64'd0);
      chk("hex_e19_99", 64'(disp_now()), 64'(pack(e99)));
      step(2);

      // Reset during a conversion of 100, then restart after release
      Value = 8'h64;
      step(1);
      chk("busy_e0_abort", 64'(busy), 64'd1);
      step(3);
      nReset = 1'b0;
      #1;
      chk("abort_display", 64'(disp_now()), 64'(pack(rst_exp)));
      chk("abort_busy", 64'({busy, zbusy}), 64'd0);
      step(2);
      nReset = 1'b1;
      conv(8'h64, e100);

      step(5);
      chk("queue_empty", 64'(q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
